// File: rtl/jtdd_prog_sdram.sv
// jtdd_prog_sdram: buffers byte-wide download writes and replays them as masked 16-bit SDRAM writes
module jtdd_prog_sdram #(
  parameter int AW     = 22,
  parameter int DEPTHW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask,
  input  logic          prog_we,
  output logic          prog_full,
  output logic          prog_ovf,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_dqm,
  input  logic          sdram_ack,
  output logic          dwnld_busy
);
  localparam int DEPTH = 1 << DEPTHW;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;
  state_t state, state_nx;
  logic [AW+9:0] mem [DEPTH];
  logic [AW+9:0] head;
  logic [DEPTHW-1:0] wr_ptr, rd_ptr;
  logic [DEPTHW:0] cnt, cnt_nx;
  logic push, pop, latch, dl_q;
  // fully masked writes carry no data, so they never occupy a slot
  assign push = prog_we & ~prog_full & (prog_mask != 2'b11);
  assign pop = (state == REQ) & sdram_ack;
  assign latch = (state == IDLE) & (cnt != '0);
  assign cnt_nx = cnt + {{DEPTHW{1'b0}}, push} - {{DEPTHW{1'b0}}, pop};
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {prog_addr, prog_data, prog_mask};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      prog_full <= 1'b0;
      prog_ovf <= 1'b0;
      dl_q <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{(DEPTHW-1){1'b0}}, push};
      rd_ptr <= rd_ptr + {{(DEPTHW-1){1'b0}}, pop};
      cnt <= cnt_nx;
      prog_full <= cnt_nx == (DEPTHW+1)'(DEPTH);
      prog_ovf <= (downloading & ~dl_q) ? 1'b0 : prog_ovf | (prog_we & prog_full);
      dl_q <= downloading;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sdram_addr <= '0;
      sdram_din <= '0;
      sdram_dqm <= '0;
    end else if (latch) begin
      sdram_addr <= head[AW+9:10];
      sdram_din <= {head[9:2], head[9:2]};
      sdram_dqm <= head[1:0];
    end
  end
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (cnt != '0 ? REQ : IDLE) :
               state == REQ  ? (sdram_ack ? GAP : REQ) : IDLE;
  always_comb begin
    sdram_req = state == REQ;
    dwnld_busy = downloading | (cnt != '0) | sdram_req;
  end
endmodule

// File: tb/tb_jtdd_prog_sdram.sv
// tb_jtdd_prog_sdram: directed and random checks of jtdd_prog_sdram against a queue-based model
module tb_jtdd_prog_sdram;
  logic clk = 0, rst_n = 0, downloading = 0, prog_we = 0, sdram_ack = 0;
  logic [21:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [1:0] prog_mask = '0;
  logic prog_full, prog_ovf, sdram_req, dwnld_busy;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0] sdram_dqm;
  int checks = 0, fails = 0;
  typedef struct packed {logic [21:0] a; logic [7:0] d; logic [1:0] m;} ent_t;
  ent_t q[$];
  ent_t m_head;
  bit m_req, m_gap, m_ovf, m_full, m_dl_q, prev_req;
  logic [21:0] obs[$];

  jtdd_prog_sdram dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
    .prog_full(prog_full), .prog_ovf(prog_ovf), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_dqm(sdram_dqm),
    .sdram_ack(sdram_ack), .dwnld_busy(dwnld_busy)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the model from pre-edge inputs, then compare.
  task automatic cycle();
    bit pop_e = 0, push_e = 0, busy_e;
    if (!rst_n) begin
      q.delete();
      m_req = 0; m_gap = 0; m_ovf = 0; m_full = 0; m_dl_q = 0;
    end else begin
      push_e = prog_we && !m_full && prog_mask != 2'b11;
      if (downloading && !m_dl_q) m_ovf = 0;
      else if (prog_we && m_full) m_ovf = 1;
      m_dl_q = downloading;
      if (m_req) begin
        if (sdram_ack) begin m_req = 0; m_gap = 1; pop_e = 1; end
      end else if (m_gap) m_gap = 0;
      else if (q.size() > 0) begin m_req = 1; m_head = q[0]; end
      if (pop_e) void'(q.pop_front());
      if (push_e) q.push_back(ent_t'{prog_addr, prog_data, prog_mask});
      m_full = q.size() == 4;
    end
    @(posedge clk);
    #1;
    busy_e = downloading || q.size() > 0 || m_req;
    checks += 4;
    if (sdram_req !== m_req) begin fails++; $display("FAIL req: got %b want %b t=%0t", sdram_req, m_req, $time); end
    if (prog_full !== m_full) begin fails++; $display("FAIL full: got %b want %b t=%0t", prog_full, m_full, $time); end
    if (prog_ovf !== m_ovf) begin fails++; $display("FAIL ovf: got %b want %b t=%0t", prog_ovf, m_ovf, $time); end
    if (dwnld_busy !== busy_e) begin fails++; $display("FAIL busy: got %b want %b t=%0t", dwnld_busy, busy_e, $time); end
    if (m_req) begin
      checks += 3;
      if (sdram_addr !== m_head.a) begin fails++; $display("FAIL addr: got %h want %h t=%0t", sdram_addr, m_head.a, $time); end
      if (sdram_din !== {m_head.d, m_head.d}) begin fails++; $display("FAIL din: got %h want %h t=%0t", sdram_din, {m_head.d, m_head.d}, $time); end
      if (sdram_dqm !== m_head.m) begin fails++; $display("FAIL dqm: got %b want %b t=%0t", sdram_dqm, m_head.m, $time); end
    end
    if (sdram_req && !prev_req) obs.push_back(sdram_addr);
    prev_req = sdram_req;
  endtask

  task automatic write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    prog_we = 1; prog_addr = a; prog_data = d; prog_mask = m;
    cycle();
    prog_we = 0;
  endtask

  task automatic ack_one();
    int n = 0;
    while (!sdram_req && n < 20) begin cycle(); n++; end
    checks++;
    if (!sdram_req) begin fails++; $display("FAIL ack_wait: req got 0 want 1 within 20 cycles"); end
    sdram_ack = 1;
    cycle();
    sdram_ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    cycle();
    checks += 5;
    if (sdram_req !== 0 || prog_full !== 0 || prog_ovf !== 0) begin fails++; $display("FAIL rst_flags: got %b%b%b want 000", sdram_req, prog_full, prog_ovf); end
    if (sdram_addr !== 0) begin fails++; $display("FAIL rst_addr: got %h want 0", sdram_addr); end
    if (sdram_din !== 0) begin fails++; $display("FAIL rst_din: got %h want 0", sdram_din); end
    if (sdram_dqm !== 0) begin fails++; $display("FAIL rst_dqm: got %b want 0", sdram_dqm); end
    if (dwnld_busy !== 0) begin fails++; $display("FAIL rst_busy: got %b want 0", dwnld_busy); end
    rst_n = 1;
    cycle();
  endtask

  task automatic test_single();
    downloading = 1;
    write(22'h00010, 8'hA5, 2'b10);
    cycle();
    checks += 4;
    if (sdram_req !== 1) begin fails++; $display("FAIL single_req: got %b want 1", sdram_req); end
    if (sdram_din !== 16'hA5A5) begin fails++; $display("FAIL single_din: got %h want a5a5", sdram_din); end
    if (sdram_dqm !== 2'b10) begin fails++; $display("FAIL single_dqm: got %b want 10", sdram_dqm); end
    if (sdram_addr !== 22'h00010) begin fails++; $display("FAIL single_addr: got %h want 00010", sdram_addr); end
    sdram_ack = 1;
    cycle();
    sdram_ack = 0;
    checks++;
    if (sdram_req !== 0) begin fails++; $display("FAIL single_ack: req got %b want 0", sdram_req); end
    idle(2);
  endtask

  task automatic test_burst();
    obs.delete();
    for (int i = 0; i < 6; i++) begin
      write(22'd100 + 22'(i), 8'(i + 1), 2'b00);
      if (i == 3) begin
        checks++;
        if (prog_full !== 1) begin fails++; $display("FAIL burst_full: got %b want 1", prog_full); end
      end
    end
    checks++;
    if (prog_ovf !== 1) begin fails++; $display("FAIL burst_ovf: got %b want 1", prog_ovf); end
    repeat (4) ack_one();
    idle(5);
    checks++;
    if (obs.size() != 4) begin fails++; $display("FAIL burst_count: got %0d want 4", obs.size()); end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== 22'd100 + 22'(i)) begin fails++; $display("FAIL burst_order[%0d]: got %h want %h", i, obs[i], 22'd100 + 22'(i)); end
    end
  endtask

  task automatic test_push_on_ack();
    obs.delete();
    for (int i = 0; i < 4; i++) write(22'd200 + 22'(i), 8'h20 + 8'(i), 2'b01);
    checks++;
    if (prog_full !== 1 || sdram_req !== 1) begin fails++; $display("FAIL poa_full: full/req got %b%b want 11", prog_full, sdram_req); end
    prog_we = 1; prog_addr = 22'h2FF; prog_data = 8'hFF; prog_mask = 2'b00; sdram_ack = 1;
    cycle();
    prog_we = 0; sdram_ack = 0;
    repeat (3) ack_one();
    write(22'd300, 8'h30, 2'b00);
    write(22'd301, 8'h31, 2'b00);
    prog_we = 1; prog_addr = 22'd302; prog_data = 8'h32; sdram_ack = 1;
    cycle();
    prog_we = 0; sdram_ack = 0;
    checks++;
    if (prog_full !== 0 || sdram_req !== 0) begin fails++; $display("FAIL poa_count2: full/req got %b%b want 00", prog_full, sdram_req); end
    repeat (2) ack_one();
    idle(4);
    checks++;
    if (obs.size() != 7) begin fails++; $display("FAIL poa_count: got %0d want 7", obs.size()); end
    for (int i = 0; i < 7 && i < obs.size(); i++) begin
      logic [21:0] e;
      e = i < 4 ? 22'd200 + 22'(i) : 22'd300 + 22'(i - 4);
      checks++;
      if (obs[i] !== e) begin fails++; $display("FAIL poa_order[%0d]: got %h want %h", i, obs[i], e); end
    end
  endtask

  task automatic test_mask_skip();
    obs.delete();
    write(22'd400, 8'h40, 2'b00);
    write(22'd401, 8'h41, 2'b11);
    write(22'd402, 8'h42, 2'b01);
    repeat (2) ack_one();
    idle(6);
    checks += 3;
    if (obs.size() != 2) begin fails++; $display("FAIL mask_count: got %0d want 2", obs.size()); end
    if (obs.size() > 0 && obs[0] !== 22'd400) begin fails++; $display("FAIL mask_first: got %h want %h", obs[0], 22'd400); end
    if (obs.size() > 1 && obs[1] !== 22'd402) begin fails++; $display("FAIL mask_second: got %h want %h", obs[1], 22'd402); end
  endtask

  task automatic test_reset_midflight();
    downloading = 1;
    write(22'd500, 8'h50, 2'b00);
    write(22'd501, 8'h51, 2'b00);
    write(22'd502, 8'h52, 2'b00);
    checks++;
    if (sdram_req !== 1) begin fails++; $display("FAIL rmf_pre: req got %b want 1", sdram_req); end
    rst_n = 0;
    cycle();
    rst_n = 1;
    checks++;
    if (sdram_req !== 0 || dwnld_busy !== downloading) begin fails++; $display("FAIL rmf_rst: req/busy got %b%b want 0%b", sdram_req, dwnld_busy, downloading); end
    sdram_ack = 1;
    cycle();
    sdram_ack = 0;
    idle(3);
    checks++;
    if (sdram_req !== 0) begin fails++; $display("FAIL rmf_late_ack: req got %b want 0", sdram_req); end
  endtask

  task automatic test_download_end();
    downloading = 1;
    write(22'd600, 8'h60, 2'b00);
    write(22'd601, 8'h61, 2'b10);
    downloading = 0;
    ack_one();
    checks++;
    if (dwnld_busy !== 1) begin fails++; $display("FAIL dend_mid: busy got %b want 1", dwnld_busy); end
    ack_one();
    checks++;
    if (dwnld_busy !== 0) begin fails++; $display("FAIL dend_last: busy got %b want 0", dwnld_busy); end
    for (int i = 0; i < 5; i++) write(22'd700 + 22'(i), 8'h70, 2'b00);
    checks++;
    if (prog_ovf !== 1) begin fails++; $display("FAIL dend_ovf_set: got %b want 1", prog_ovf); end
    repeat (4) ack_one();
    idle(2);
    downloading = 1;
    cycle();
    checks++;
    if (prog_ovf !== 0) begin fails++; $display("FAIL dend_ovf_clr: got %b want 0", prog_ovf); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      prog_we = $urandom_range(0, 1);
      prog_addr = 22'($urandom);
      prog_data = 8'($urandom);
      prog_mask = 2'($urandom);
      sdram_ack = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 40) == 0) downloading = ~downloading;
      rst_n = $urandom_range(0, 150) != 0;
      cycle();
    end
    prog_we = 0; sdram_ack = 0; rst_n = 1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_push_on_ack();
    test_mask_skip();
    test_reset_midflight();
    test_download_end();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
